// File: rtl/chip_pkg.sv
// rtl/chip_pkg.sv - shared Chip geometry, burst FSM states and request record
package chip_pkg;

  localparam int DEF_BGWIDTH      = 2;
  localparam int DEF_BAWIDTH      = 2;
  localparam int DEF_COLWIDTH     = 10;
  localparam int DEF_DEVICE_WIDTH = 4;
  localparam int DEF_BL           = 8;
  localparam int DEF_CHWIDTH      = 5;
  localparam int DEF_RD_LAT       = 1;

  localparam int BANKGROUPS    = 2 ** DEF_BGWIDTH;
  localparam int BANKSPERGROUP = 2 ** DEF_BAWIDTH;
  localparam int COLS          = 2 ** DEF_COLWIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic                       wr;
    logic [DEF_BGWIDTH-1:0]     bg;
    logic [DEF_BAWIDTH-1:0]     ba;
    logic [DEF_CHWIDTH-1:0]     row;
    logic [DEF_COLWIDTH-1:0]    col;
  } req_t;

endpackage

// File: rtl/chip_rd_pipe.sv
// rtl/chip_rd_pipe.sv - read-latency valid/bank-select pipeline with registered rdata
module chip_rd_pipe
  import chip_pkg::*;
#(
  parameter int BGWIDTH      = DEF_BGWIDTH,
  parameter int BAWIDTH      = DEF_BAWIDTH,
  parameter int DEVICE_WIDTH = DEF_DEVICE_WIDTH,
  parameter int RD_LAT       = DEF_RD_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue,
  input  logic [BGWIDTH-1:0]      bg,
  input  logic [BAWIDTH-1:0]      ba,
  input  logic [DEVICE_WIDTH-1:0] dqout [2**BGWIDTH][2**BAWIDTH],
  output logic                    rdata_valid,
  output logic [DEVICE_WIDTH-1:0] rdata,
  output logic                    busy
);

  logic [RD_LAT-1:0]  vld;
  logic [BGWIDTH-1:0] bg_sr [RD_LAT];
  logic [BAWIDTH-1:0] ba_sr [RD_LAT];

  // Anything issued or still in flight keeps the drain phase waiting.
  assign busy = issue | (|vld);

  // Age each issued beat by RD_LAT cycles, carrying the bank it addressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        bg_sr[i] <= '0;
        ba_sr[i] <= '0;
      end
    end else begin
      vld[0]   <= issue;
      bg_sr[0] <= bg;
      ba_sr[0] <= ba;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i]   <= vld[i-1];
        bg_sr[i] <= bg_sr[i-1];
        ba_sr[i] <= ba_sr[i-1];
      end
    end
  end

  // Capture the addressed bank's dqout once its latency has elapsed; zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      rdata_valid <= vld[RD_LAT-1];
      rdata       <= vld[RD_LAT-1] ? dqout[bg_sr[RD_LAT-1]][ba_sr[RD_LAT-1]] : '0;
    end
  end

endmodule

// File: rtl/chip_burst_driver.sv
// rtl/chip_burst_driver.sv - expands host burst requests into per-beat Chip bank accesses
module chip_burst_driver
  import chip_pkg::*;
#(
  parameter int BGWIDTH      = DEF_BGWIDTH,
  parameter int BAWIDTH      = DEF_BAWIDTH,
  parameter int COLWIDTH     = DEF_COLWIDTH,
  parameter int DEVICE_WIDTH = DEF_DEVICE_WIDTH,
  parameter int BL           = DEF_BL,
  parameter int CHWIDTH      = DEF_CHWIDTH,
  parameter int RD_LAT       = DEF_RD_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [BGWIDTH-1:0]      req_bg,
  input  logic [BAWIDTH-1:0]      req_ba,
  input  logic [CHWIDTH-1:0]      req_row,
  input  logic [COLWIDTH-1:0]     req_col,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DEVICE_WIDTH-1:0] wdata,
  output logic                    rdata_valid,
  output logic [DEVICE_WIDTH-1:0] rdata,
  output logic                    done,
  output logic                    rd_o_wr [2**BGWIDTH][2**BAWIDTH],
  output logic [DEVICE_WIDTH-1:0] dqin    [2**BGWIDTH][2**BAWIDTH],
  output logic [CHWIDTH-1:0]      row     [2**BGWIDTH][2**BAWIDTH],
  output logic [COLWIDTH-1:0]     column  [2**BGWIDTH][2**BAWIDTH],
  input  logic [DEVICE_WIDTH-1:0] dqout   [2**BGWIDTH][2**BAWIDTH]
);

  localparam int NBG = 2 ** BGWIDTH;
  localparam int NBA = 2 ** BAWIDTH;
  localparam int BCW = $clog2(BL) + 1;

  state_t                 state, state_nxt;
  logic [BCW-1:0]         beat;
  logic [BGWIDTH-1:0]     bg_q;
  logic [BAWIDTH-1:0]     ba_q;
  logic [CHWIDTH-1:0]     row_q;
  logic [COLWIDTH-1:0]    col_q;
  logic                   issue_q;
  logic                   pipe_busy;
  logic                   last_beat;
  logic                   burst_end;
  logic [COLWIDTH-1:0]    beat_col;

  logic                   n_we;
  logic [DEVICE_WIDTH-1:0] n_dq;
  logic [CHWIDTH-1:0]     n_row;
  logic [COLWIDTH-1:0]    n_col;
  logic                   n_issue;

  assign last_beat = (beat == BCW'(BL - 1));
  assign burst_end = (beat == BCW'(BL));
  assign beat_col  = col_q + COLWIDTH'(beat);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, host handshakes and the target bank's next lane values.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    done        = 1'b0;
    n_we        = 1'b0;
    n_dq        = '0;
    n_row       = '0;
    n_col       = '0;
    n_issue     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_wr ? WRITE : READ;
      end
      WRITE: begin
        if (burst_end) begin
          // Last beat is on the lanes this cycle; lanes clear on the way out.
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          wdata_ready = 1'b1;
          // A stall keeps the address but withdraws the write strobe and data.
          n_row = row[bg_q][ba_q];
          n_col = column[bg_q][ba_q];
          if (wdata_valid) begin
            n_we  = 1'b1;
            n_dq  = wdata;
            n_row = row_q;
            n_col = beat_col;
          end
        end
      end
      READ: begin
        n_row   = row_q;
        n_col   = beat_col;
        n_issue = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rdata_valid && !pipe_busy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter: restarts on accept, advances per accepted write beat or issued read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else begin
      case (state)
        IDLE:    if (req_valid) beat <= '0;
        WRITE:   if (wdata_valid && !burst_end) beat <= beat + BCW'(1);
        READ:    beat <= beat + BCW'(1);
        default: ;
      endcase
    end
  end

  // Latch the request address when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_q  <= '0;
      ba_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (state == IDLE && req_valid) begin
      bg_q  <= req_bg;
      ba_q  <= req_ba;
      row_q <= req_row;
      col_q <= req_col;
    end
  end

  // Registered Chip lanes: only the latched bank ever carries non-zero values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NBG; g++) begin
        for (int b = 0; b < NBA; b++) begin
          rd_o_wr[g][b] <= 1'b0;
          dqin[g][b]    <= '0;
          row[g][b]     <= '0;
          column[g][b]  <= '0;
        end
      end
    end else begin
      for (int g = 0; g < NBG; g++) begin
        for (int b = 0; b < NBA; b++) begin
          if (BGWIDTH'(g) == bg_q && BAWIDTH'(b) == ba_q) begin
            rd_o_wr[g][b] <= n_we;
            dqin[g][b]    <= n_dq;
            row[g][b]     <= n_row;
            column[g][b]  <= n_col;
          end else begin
            rd_o_wr[g][b] <= 1'b0;
            dqin[g][b]    <= '0;
            row[g][b]     <= '0;
            column[g][b]  <= '0;
          end
        end
      end
    end
  end

  // Marks the cycles in which a read address is presented on the Chip port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_q <= 1'b0;
    else        issue_q <= n_issue;
  end

  chip_rd_pipe #(
    .BGWIDTH      (BGWIDTH),
    .BAWIDTH      (BAWIDTH),
    .DEVICE_WIDTH (DEVICE_WIDTH),
    .RD_LAT       (RD_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (issue_q),
    .bg          (bg_q),
    .ba          (ba_q),
    .dqout       (dqout),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .busy        (pipe_busy)
  );

endmodule
